conv_layer_sequencer: RTL

- Parametrised successor to the fixed 3x3-array, 2-kernel conv layer controller.
- Sequences one full convolution layer over a PARA_X x PARA_Y MAC array with PARA_KERNEL parallel kernels.
- Generates feature-map window coordinates and weight read addresses for every output tile and kernel group, resets and drains the conv units, and hands results to the writeback path through a valid/ready handshake.
- Sits between the layer-level control (start/done) and the feature-map RAM, weight RAM and conv-unit array.

---
 rtl/conv_layer_sequencer_if.sv | 12 +
 rtl/conv_layer_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_sequencer_if.sv
// conv_layer_sequencer_if: result writeback handshake between the sequencer and the writeback path
interface conv_layer_sequencer_if #(
  parameter int FM_SIZE_WIDTH = 8
);
  logic out_valid;
  logic out_ready;
  logic [FM_SIZE_WIDTH-1:0] out_kernel;
  logic [FM_SIZE_WIDTH-1:0] out_row;
  logic [FM_SIZE_WIDTH-1:0] out_col;
  modport master(output out_valid, out_kernel, out_row, out_col, input out_ready);
  modport slave(input out_valid, out_kernel, out_row, out_col, output out_ready);
endinterface

// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer: tiles one conv layer over a PARA_X x PARA_Y MAC array, streams windows/weights, writes back results
// Optional CONV_SEQ_PERF_CNT_EN adds stream_cycles/stall_cycles performance counters.
module conv_layer_sequencer #(
  parameter int PARA_X = 3,
  parameter int PARA_Y = 3,
  parameter int PARA_KERNEL = 2,
  parameter int KERNEL_SIZE_WIDTH = 6,
  parameter int FM_SIZE_WIDTH = 8,
  parameter int WEIGHT_ADDR_WIDTH = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic [KERNEL_SIZE_WIDTH-1:0] kernel_size,
  input  logic [FM_SIZE_WIDTH-1:0] fm_size,
  input  logic [FM_SIZE_WIDTH-1:0] kernel_num,
  output logic busy,
  output logic done,
  output logic conv_rst,
  output logic mac_valid,
  output logic [FM_SIZE_WIDTH-1:0] fm_row,
  output logic [FM_SIZE_WIDTH-1:0] fm_col,
  output logic [WEIGHT_ADDR_WIDTH-1:0] weight_addr_read,
  output logic [PARA_X-1:0] row_mask,
  output logic [PARA_Y-1:0] col_mask,
  input  logic [PARA_KERNEL-1:0] conv_out_ready,
`ifdef CONV_SEQ_PERF_CNT_EN
  output logic [31:0] stream_cycles,
  output logic [31:0] stall_cycles,
`endif
  conv_layer_sequencer_if.master wb
);
  localparam int W = FM_SIZE_WIDTH + 2;
  typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, WRITE, NEXT, FIN} state_t;
  state_t state;
  logic [KERNEL_SIZE_WIDTH-1:0] ks_r, kr, kc;
  logic [FM_SIZE_WIDTH-1:0] fm_r, kn_r, row_base, col_base, kbase;
  logic [WEIGHT_ADDR_WIDTH-1:0] wbase;
  logic [W-1:0] os, nk;
  logic [PARA_X-1:0] rm;
  logic [PARA_Y-1:0] cm;
  logic last_c, last_r, last_g, last_kc, last_kr, more_k;
  assign os = W'(fm_r) - W'(ks_r) + W'(1);
  assign last_c = W'(col_base) + W'(PARA_Y) >= os;
  assign last_r = W'(row_base) + W'(PARA_X) >= os;
  assign last_g = W'(kbase) + W'(PARA_KERNEL) >= W'(kn_r);
  assign last_kc = kc == ks_r - 1'b1;
  assign last_kr = kr == ks_r - 1'b1;
  assign nk = W'(wb.out_kernel) + W'(1);
  assign more_k = nk < W'(kbase) + W'(PARA_KERNEL) && nk < W'(kn_r);
  always_comb begin
    rm = '0;
    cm = '0;
    for (int i = 0; i < PARA_X; i++) rm[i] = W'(row_base) + W'(i) < os;
    for (int j = 0; j < PARA_Y; j++) cm[j] = W'(col_base) + W'(j) < os;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      conv_rst <= 1'b0;
      mac_valid <= 1'b0;
      fm_row <= '0;
      fm_col <= '0;
      weight_addr_read <= '0;
      row_mask <= '0;
      col_mask <= '0;
      wb.out_valid <= 1'b0;
      wb.out_kernel <= '0;
      wb.out_row <= '0;
      wb.out_col <= '0;
      ks_r <= '0;
      fm_r <= '0;
      kn_r <= '0;
      kr <= '0;
      kc <= '0;
      row_base <= '0;
      col_base <= '0;
      kbase <= '0;
      wbase <= '0;
    end else if (abort) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      conv_rst <= 1'b0;
      mac_valid <= 1'b0;
      fm_row <= '0;
      fm_col <= '0;
      weight_addr_read <= '0;
      row_mask <= '0;
      col_mask <= '0;
      wb.out_valid <= 1'b0;
      wb.out_kernel <= '0;
      wb.out_row <= '0;
      wb.out_col <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          ks_r <= kernel_size;
          fm_r <= fm_size;
          kn_r <= kernel_num;
          row_base <= '0;
          col_base <= '0;
          kbase <= '0;
          wbase <= '0;
          busy <= 1'b1;
          state <= LOAD;
        end
        LOAD: begin
          conv_rst <= 1'b1;
          mac_valid <= 1'b1;
          kr <= '0;
          kc <= '0;
          fm_row <= row_base;
          fm_col <= col_base;
          weight_addr_read <= wbase;
          row_mask <= rm;
          col_mask <= cm;
          state <= STREAM;
        end
        STREAM: if (last_kc && last_kr) begin
          mac_valid <= 1'b0;
          state <= DRAIN;
        end else begin
          // weight address runs linearly; it ends on the group's last word, which seeds the next group base
          weight_addr_read <= weight_addr_read + 1'b1;
          kc <= last_kc ? '0 : kc + 1'b1;
          kr <= last_kc ? kr + 1'b1 : kr;
          fm_col <= last_kc ? col_base : fm_col + 1'b1;
          fm_row <= last_kc ? fm_row + 1'b1 : fm_row;
        end
        DRAIN: if (&conv_out_ready) begin
          wb.out_valid <= 1'b1;
          wb.out_kernel <= kbase;
          wb.out_row <= row_base;
          wb.out_col <= col_base;
          state <= WRITE;
        end
        WRITE: if (wb.out_ready) begin
          if (more_k) wb.out_kernel <= wb.out_kernel + 1'b1;
          else begin
            wb.out_valid <= 1'b0;
            state <= NEXT;
          end
        end
        NEXT: begin
          conv_rst <= 1'b0;
          col_base <= last_c ? '0 : col_base + FM_SIZE_WIDTH'(PARA_Y);
          if (last_c) row_base <= last_r ? '0 : row_base + FM_SIZE_WIDTH'(PARA_X);
          if (last_c && last_r && !last_g) begin
            kbase <= kbase + FM_SIZE_WIDTH'(PARA_KERNEL);
            wbase <= weight_addr_read + 1'b1;
          end
          if (last_c && last_r && last_g) begin
            done <= 1'b1;
            busy <= 1'b0;
            state <= FIN;
          end else state <= LOAD;
        end
        FIN: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef CONV_SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stream_cycles <= '0;
      stall_cycles <= '0;
    end else if (state == IDLE && start && !abort) begin
      stream_cycles <= '0;
      stall_cycles <= '0;
    end else begin
      if (mac_valid) stream_cycles <= stream_cycles + 1'b1;
      if (state == DRAIN || (state == WRITE && wb.out_valid && !wb.out_ready)) stall_cycles <= stall_cycles + 1'b1;
    end
`endif
endmodule
